// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the VGA write scheduler.
// Entry layout mirrors what the drain side needs: target select, word address, byte.
package vga_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic        is_con;
      logic [13:0] addr;
      logic [7:0]  data;
   } wr_entry_t;

   localparam logic [23:0] CON_DECODE_MASK = 24'hFFFFFF;
   localparam logic [3:0]  STAT_CLR_OFS    = 4'h4;

endpackage

// File: rtl/sched_fifo.sv
// In-order write FIFO: head is combinational from the read pointer, push/pop take effect at the edge.
// Push is ignored when full and pop when empty; the caller gates on the registered flags.
module sched_fifo
   import vga_sched_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  wr_entry_t     din,
   input  logic          pop,
   output wr_entry_t     head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   wr_entry_t       mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic            push_ok;
   logic            pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + AW'(1);
         if (pop_ok)  rptr <= rptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= din;
   end

endmodule

// File: rtl/vga_write_sched.sv
// Posts AHB writes into a FIFO and drains them in order to the console or image port; strobes 2 cycles after the data phase.
// The bus stalls only when a write data phase meets a full FIFO; console drains wait while scroll is high.
module vga_write_sched
   import vga_sched_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [1:0]  HTRANS,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   input  logic        scroll,
   output logic        console_we,
   output logic [7:0]  console_wdata,
   output logic        image_we,
   output logic [13:0] image_addr,
   output logic [7:0]  image_wdata
);

   wr_entry_t      head;
   wr_entry_t      entry;
   logic           full;
   logic           empty;
   logic [CW-1:0]  count;
   logic           push;
   logic           pop;
   logic           stall;
   logic           wr_req;
   logic           rd_req;
   logic           wr_pend;
   logic           rd_pend;
   logic           rd_clr;
   logic           con_q;
   logic [13:0]    addr_q;
   logic [15:0]    stall_cnt;
   sched_state_t   state;
   sched_state_t   state_nx;
   logic           unused_bits;

   assign unused_bits = ^{HADDR[31:24], HWDATA[31:8]};

   assign wr_req    = HSEL & HWRITE & HTRANS[1];
   assign rd_req    = HSEL & !HWRITE & HTRANS[1];
   assign stall     = wr_pend && full;
   assign push      = wr_pend && !full;
   assign pop       = !empty && (!head.is_con || !scroll);
   assign HREADYOUT = !stall;
   assign entry     = {con_q, addr_q, HWDATA[7:0]};

   // A stalled write keeps its captured address phase until it is pushed.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_pend <= 1'b0;
         rd_pend <= 1'b0;
         rd_clr  <= 1'b0;
         con_q   <= 1'b0;
         addr_q  <= '0;
      end else if (HREADY && !stall) begin
         wr_pend <= wr_req;
         rd_pend <= rd_req;
         rd_clr  <= (HADDR[3:0] == STAT_CLR_OFS);
         con_q   <= ((HADDR[23:0] & CON_DECODE_MASK) == 24'h0);
         addr_q  <= HADDR[15:2];
      end
   end

   sched_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .push  (push),
      .din   (entry),
      .pop   (pop),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (push) state_nx = RUN;
         RUN: begin
            if (!empty && head.is_con && scroll)
               state_nx = HOLD;
            else if (pop && (count == CW'(1)) && !push)
               state_nx = IDLE;
         end
         HOLD:    if (!scroll) state_nx = RUN;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= IDLE;
         stall_cnt <= '0;
      end else begin
         state <= state_nx;
         if (rd_pend && rd_clr)
            stall_cnt <= '0;
         else if ((state == HOLD) && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         console_we    <= 1'b0;
         console_wdata <= '0;
         image_we      <= 1'b0;
         image_addr    <= '0;
         image_wdata   <= '0;
      end else begin
         console_we    <= pop && head.is_con;
         console_wdata <= (pop && head.is_con) ? head.data : 8'h0;
         image_we      <= pop && !head.is_con;
         image_addr    <= (pop && !head.is_con) ? head.addr : 14'h0;
         image_wdata   <= (pop && !head.is_con) ? head.data : 8'h0;
      end
   end

   assign HRDATA = rd_pend ? {stall_cnt, 8'h00, 2'(state), scroll, full, empty, 3'(count)}
                           : 32'h0;

endmodule

// File: tb/tb_vga_write_sched.sv
// Directed bench for vga_write_sched: bus tasks drive AHB transfers, a scoreboard queue checks drain order.
module tb_vga_write_sched;
   import vga_sched_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        scroll;
   logic        console_we;
   logic [7:0]  console_wdata;
   logic        image_we;
   logic [13:0] image_addr;
   logic [7:0]  image_wdata;

   vga_write_sched dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .HSEL          (HSEL),
      .HADDR         (HADDR),
      .HWRITE        (HWRITE),
      .HTRANS        (HTRANS),
      .HREADY        (HREADY),
      .HWDATA        (HWDATA),
      .HREADYOUT     (HREADYOUT),
      .HRDATA        (HRDATA),
      .scroll        (scroll),
      .console_we    (console_we),
      .console_wdata (console_wdata),
      .image_we      (image_we),
      .image_addr    (image_addr),
      .image_wdata   (image_wdata)
   );

   assign HREADY = HREADYOUT;
   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   int          n_chk = 0;
   int          n_pass = 0;
   wr_entry_t   sb[$];
   wr_entry_t   mon_e;
   logic [31:0] pend_wd;
   logic [1:0]  last_stb;
   logic [1:0]  stb_or;
   logic [31:0] last_rd;
   int          last_stall;
   int          stall_sum;
   int          c2;
   int          c_rel;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // One bus cycle (longer if the previous data phase is stalled); returns after the next edge + #1.
   task automatic bus(input logic sel, input logic wr, input logic [31:0] addr);
      HSEL   = sel;
      HWRITE = wr;
      HTRANS = sel ? 2'b10 : 2'b00;
      HADDR  = addr;
      HWDATA = pend_wd;
      last_stall = 0;
      forever begin
         @(negedge HCLK);
         last_stb = {console_we, image_we};
         last_rd  = HRDATA;
         if (HREADYOUT) break;
         last_stall++;
         stall_sum++;
         if (last_stall > 50) begin
            check("hready_timeout", 32'(HREADYOUT), 32'h1);
            break;
         end
         @(posedge HCLK);
      end
      @(posedge HCLK);
      #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [7:0] d);
      bus(1'b1, 1'b1, addr);
      pend_wd = {24'h0, d};
      sb.push_back({(addr[23:0] == 24'h0), addr[15:2], d});
   endtask

   task automatic rd(input logic [31:0] addr);
      bus(1'b1, 1'b0, addr);
      pend_wd = 32'h0;
   endtask

   task automatic idle();
      bus(1'b0, 1'b0, 32'h0);
      pend_wd = 32'h0;
   endtask

   always @(negedge HCLK) begin
      if (HRESETn && (console_we || image_we)) begin
         if (sb.size() == 0) begin
            check("stale_strobe", 32'({console_we, image_we}), 32'h0);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_con)
               check("con_strobe", {console_we, image_we, console_wdata, image_addr, image_wdata},
                     {2'b10, mon_e.data, 14'h0, 8'h0});
            else
               check("img_strobe", {console_we, image_we, console_wdata, image_addr, image_wdata},
                     {2'b01, 8'h0, mon_e.addr, mon_e.data});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn = 1'b0;
      HSEL = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HADDR = '0; HWDATA = '0;
      scroll = 1'b0; pend_wd = '0; stall_sum = 0;
      repeat (2) @(posedge HCLK);
      #1;
      check("reset_hrdata", HRDATA, 32'h0);
      check("reset_ctl", 32'({HREADYOUT, console_we, image_we, image_addr, console_wdata}),
            32'({1'b1, 2'b00, 14'h0, 8'h0}));
      check("reset_img_data", 32'(image_wdata), 32'h0);
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;

      // Test 1: console write latency
      wr(32'h0, 8'h41);
      idle(); check("t1_T", 32'(last_stb), 32'h0);
      idle(); check("t1_T1", 32'(last_stb), 32'h0);
      idle(); check("t1_T2_strobe", 32'(last_stb), 32'h2);

      // Test 2: image write
      wr(32'h0000_0010, 8'h5A);
      repeat (4) idle();
      check("t2_drained", 32'(sb.size()), 32'h0);
      check("t12_no_stall", 32'(stall_sum), 32'h0);

      // Test 3: fill FIFO while scrolling, 9th write stalls
      rd(32'h4); idle();
      scroll = 1'b1;
      stall_sum = 0;
      for (int k = 0; k < 9; k++) begin
         if (k == 1) c2 = cyc;
         wr(32'h0, 8'h30 + 8'(k));
      end
      check("t3_first8_no_stall", 32'(stall_sum), 32'h0);
      fork
         begin
            repeat (4) @(posedge HCLK);
            #1;
            scroll = 1'b0;
            c_rel = cyc;
         end
      join_none
      idle();
      check("t3_9th_stall", 32'(last_stall), 32'd5);
      repeat (12) idle();
      check("t3_drained", 32'(sb.size()), 32'h0);
      rd(32'h0); idle();
      check("t3_stall_cnt", last_rd, {16'(c_rel - c2 - 1), 16'h0008});

      // Test 4: mixed order held behind a console head
      rd(32'h4); idle();
      scroll = 1'b1;
      wr(32'h0, 8'h41);
      wr(32'h0000_0020, 8'h77);
      wr(32'h0, 8'h42);
      idle();
      stb_or = 2'b00;
      for (int k = 0; k < 4; k++) begin
         idle();
         stb_or = stb_or | last_stb;
      end
      check("t4_quiet", 32'(stb_or), 32'h0);
      scroll = 1'b0;
      idle(); check("t4_s0", 32'(last_stb), 32'h0);
      idle(); check("t4_s1_con", 32'(last_stb), 32'h2);
      idle(); check("t4_s2_img", 32'(last_stb), 32'h1);
      idle(); check("t4_s3_con", 32'(last_stb), 32'h2);

      // Test 5: status word in HOLD, then clear
      rd(32'h4); idle();
      scroll = 1'b1;
      wr(32'h0, 8'h78);
      wr(32'h0000_0040, 8'h11);
      wr(32'h0, 8'h79);
      repeat (3) idle();
      rd(32'h0); idle();
      check("t5_status_lo", 32'(last_rd[7:0]), 32'hA3);
      check("t5_stall_nonzero", 32'(last_rd[31:16] != 16'h0), 32'h1);
      scroll = 1'b0;
      repeat (6) idle();
      check("t5_drained", 32'(sb.size()), 32'h0);
      rd(32'h4); rd(32'h0); idle();
      check("t5_cleared", last_rd, 32'h0000_0008);

      // Test 6: reset with entries queued
      scroll = 1'b1;
      for (int k = 0; k < 5; k++) wr(32'h0, 8'h60 + 8'(k));
      idle(); idle();
      HRESETn = 1'b0;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      sb.delete();
      pend_wd = '0;
      @(negedge HCLK);
      check("t6_reset_outs", 32'({HREADYOUT, console_we, image_we}), 32'h4);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      rd(32'h0); idle();
      check("t6_empty_status", last_rd, 32'h0000_0028);
      scroll = 1'b0;
      stb_or = 2'b00;
      for (int k = 0; k < 10; k++) begin
         idle();
         stb_or = stb_or | last_stb;
      end
      check("t6_no_stale", 32'(stb_or), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_write_sched.md
Name: vga_write_sched

Overview:
- Write scheduler between the AHB-Lite bus and the VGA console/image write ports.
- Posts AHB writes into an in-order FIFO and drains them to the console port or the image port.
- Console writes are held while the console is scrolling, so the bus stalls only when the FIFO is full, not for the whole scroll.
- Reads return a status word. Sits between the AHB decoder and the console/image buffers inside the VGA peripheral.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CW, 4, count width; equals log2(DEPTH)+1.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  address-phase address
- HWRITE  in  1  address-phase write flag
- HTRANS  in  2  transfer type; bit1 = NONSEQ/SEQ
- HREADY  in  1  bus ready
- HWDATA  in  32  data-phase write data; bits [7:0] used
- HREADYOUT  out  1  low only while a write data phase waits on a full FIFO
- HRDATA  out  32  status word
- scroll  in  1  console busy scrolling; console drains blocked while high
- console_we  out  1  one-cycle console write strobe
- console_wdata  out  8  console character
- image_we  out  1  one-cycle image write strobe
- image_addr  out  14  image word address
- image_wdata  out  8  image pixel data

Behaviour:
- Reset values: HREADYOUT=1, HRDATA=0, all we=0, all data/addr=0, FIFO empty, stall_cnt=0, state IDLE.
- Address phase is captured when HREADY=1. The captured phase is a write if HSEL & HWRITE & HTRANS[1], and a read if HSEL & !HWRITE & HTRANS[1].
- Target decode:
  - Console when captured HADDR[23:0]==0; otherwise image.
  - Image address is HADDR[15:2].
- Write data phase: push {is_con, addr[13:0], HWDATA[7:0]} into the FIFO, but only when full==0 (registered full; no same-cycle pop credit).
- If full: HREADYOUT=0 combinationally. Hold the pending write and retry each cycle; push on the first cycle with full==0, where HREADYOUT=1 completes the transfer.
- Drain rule: pop the head when !empty && (!head.is_con || !scroll). At most one pop per cycle, strictly in order; a blocked console head also blocks the image entries behind it.
- Drain outputs are registered. The strobe rises in the cycle after the pop and lasts one cycle; data/addr are valid with the strobe and return to 0 otherwise.
- Latency, empty FIFO, scroll=0: data phase in cycle T → entry written at end of T → pop in T+1 → strobe high in T+2.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Pointers wrap modulo DEPTH; count is 0..DEPTH.
- FSM (registered):
  - IDLE: FIFO empty. Goes to RUN on push.
  - RUN: draining. Goes to HOLD when head.is_con && scroll; goes to IDLE when the last entry pops with no push that cycle.
  - HOLD: console head blocked. Goes to RUN when scroll=0.
  - stall_cnt increments each cycle in HOLD and saturates at 16'hFFFF.
- Read data phase: HRDATA = {stall_cnt[15:0], 8'h0, state[1:0], scroll, full, empty, count[2:0] zero-extended from CW}. HRDATA is 0 in all other cycles. Reads never stall.
- A read of offset 0x4 clears stall_cnt; a same-cycle increment is lost.
- HRESETn assertion mid-operation immediately empties the FIFO, drops strobes and returns to IDLE. Entries in flight are discarded.
- Writes with HTRANS IDLE/BUSY, or with HSEL=0, are ignored.

Decomposition:
- Package vga_sched_pkg:
  - enum sched_state_t {IDLE=2'd0, RUN=2'd1, HOLD=2'd2}
  - struct wr_entry_t {is_con, addr[13:0], data[7:0]} (23 bits)
  - localparams CON_DECODE_MASK=24'hFFFFFF, STAT_CLR_OFS=4'h4
- One sub-module: sched_fifo, a synchronous FIFO of wr_entry_t with push/pop/full/empty/count and asynchronous active-low reset.
- FSM, decode and AHB handling live in the top.

Test Plan:
1. Single console write 0x41 to addr 0x0, scroll=0 → console_we high exactly 2 cycles after the data phase with console_wdata=0x41; HREADYOUT stays 1.
2. Image write 0x5A to addr 0x0000_0010 → image_we pulse with image_addr=14'h0004, image_wdata=0x5A; console_we stays 0.
3. Hold scroll=1, issue 9 back-to-back console writes (DEPTH=8):
   - first 8 complete with HREADYOUT=1;
   - 9th data phase sees HREADYOUT=0 until scroll drops;
   - then 9 strobes in order; stall_cnt equals the HOLD cycles.
4. Queue console 'A', image write, console 'B' while scroll=1 → no strobes while scroll=1; after release, order is console A, image, console B on consecutive strobes.
5. Read status with 3 queued entries and scroll=1 → HRDATA[3:0]=3, empty=0, full=0, scroll=1, state=HOLD; a read of offset 0x4 then a status read → stall_cnt=0.
6. Assert HRESETn low with 5 entries queued → next cycle count=0, all strobes 0, HREADYOUT=1; after release no stale strobes appear.
